// File: rtl/sequential_carryless_multiplier.sv
// Iterative GF(2) multiplier: BITS_PER_CYCLE multiplier bits per clock, returning the
// low, high or reversed word of the 2W-bit carry-less product.
module sequential_carryless_multiplier #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("BITS_PER_CYCLE must divide DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic [2*W-1:0]   pp;

  function automatic logic [W-1:0] sel_word(input logic [1:0] m, input logic [2*W-1:0] p);
    case (m)
      2'b01:   return p[2*W-1:W];
      2'b10:   return p[2*W-2:W-1];
      default: return p[W-1:0];
    endcase
  endfunction

  // a_q is pre-shifted by the bits already consumed, so bit j of b_q weighs a_q << j.
  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_q[j]) pp = pp ^ (a_q << j);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          a_d     = {{W{1'b0}}, operand_A_i};
          b_d     = operand_B_i;
          mode_d  = mode_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_q ^ pp;
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = sel_word(mode_q, acc_q ^ pp);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule
